// File: rtl/sync_fifo_8x8.sv
// Single-clock byte FIFO with registered read port, occupancy count and
// sticky overflow/underflow flags for the upstream write-pattern FSM.
module sync_fifo_8x8 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  fifo_words,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_ovf;
  logic              r_unf;

  logic w_full;
  logic w_empty;
  logic w_wr_acc;
  logic w_rd_acc;

  // Status decoded from the registered count so it moves with fifo_words.
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = wr_en & ~w_full;
  assign w_rd_acc = rd_en & ~w_empty;

  // Storage carries no reset; stale entries are never readable.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  // A violation in the same cycle as clr_err keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~clr_err) | (wr_en & w_full);
      r_unf <= (r_unf & ~clr_err) | (rd_en & w_empty);
    end
  end

  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign fifo_words = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overflow   = r_ovf;
  assign underflow  = r_unf;

endmodule

// File: tb/tb_sync_fifo_8x8.sv
// Directed self-checking bench for sync_fifo_8x8: fill/overflow, drain/underflow,
// wrap-around, simultaneous read+write and asynchronous mid-run reset.
module tb_sync_fifo_8x8;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] fifo_words;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int n_total = 0;
  int n_bad   = 0;

  sync_fifo_8x8 #(.DATA_W(8), .DEPTH(8), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_words (fifo_words),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow),
    .clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: apply request, let the edge pass, then drop requests.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    clr_err = clr;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] exp_q [$];

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    chk("rst_words", fifo_words, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);

    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("fill_words", fifo_words, i + 1);
      chk("fill_empty", empty, 0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
      chk("fill2_words", fifo_words, i + 6);
    end
    chk("full_set", full, 1);
    chk("ovf_before", overflow, 0);

    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_words", fifo_words, 8);
    chk("ovf_flag", overflow, 1);
    chk("ovf_full", full, 1);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      v = (i < 5) ? 8'hAA : 8'hA1 + 8'(i - 5);
      chk("drain_data", rd_data, v);
      chk("drain_valid", rd_valid, 1);
      chk("drain_words", fifo_words, 7 - i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_full", full, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("idle_valid", rd_valid, 0);
    chk("idle_hold", rd_data, 8'hA3);

    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("unf_flag", underflow, 1);
    chk("unf_valid", rd_valid, 0);
    chk("unf_words", fifo_words, 0);
    chk("ovf_sticky", overflow, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", overflow, 0);
    chk("clr_unf", underflow, 0);

    v = 8'h00;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        step(1'b1, v, 1'b0, 1'b0);
        exp_q.push_back(v);
        v++;
      end
      chk("wrap_words", fifo_words, 6);
      for (int i = 0; i < 6; i++) begin
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_data", rd_data, exp_q.pop_front());
        chk("wrap_valid", rd_valid, 1);
      end
      chk("wrap_empty", empty, 1);
    end
    chk("wrap_last", rd_data, 8'h11);

    for (int i = 0; i < 4; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h24, 1'b1, 1'b0);
    chk("both4_words", fifo_words, 4);
    chk("both4_data", rd_data, 8'h20);
    chk("both4_valid", rd_valid, 1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h25 + 8'(i), 1'b0, 1'b0);
    chk("both8_pre", fifo_words, 8);
    step(1'b1, 8'h99, 1'b1, 1'b0);
    chk("both8_words", fifo_words, 7);
    chk("both8_ovf", overflow, 1);
    chk("both8_data", rd_data, 8'h21);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("both8_drain", rd_data, 8'h22 + 8'(i));
    end
    chk("both8_empty", empty, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("both8_clr", overflow, 0);

    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("both0_words", fifo_words, 1);
    chk("both0_unf", underflow, 1);
    chk("both0_valid", rd_valid, 0);
    chk("both0_nobyp", rd_data, 8'h28);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("both0_read", rd_data, 8'h77);

    // Clear and hold underflow: clr_err with a new violation keeps the flag.
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("clr_setwins", underflow, 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_unf2", underflow, 0);

    for (int i = 0; i < 6; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h36, 1'b0, 1'b0);
    chk("pre_rst_words", fifo_words, 6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_words", fifo_words, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_data", rd_data, 8'h00);
    chk("arst_valid", rd_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("post_words", fifo_words, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_data", rd_data, 8'h55);
    chk("post_valid", rd_valid, 1);
    chk("post_empty", empty, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
